instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential fetch with credit-based flow control,
// an in-order response FIFO feeding the core, and redirect handling that
// discards responses to requests issued before the redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   push_pc_q, push_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];

  logic [SW-1:0] credit_used;
  logic [31:0]   redirect_target;
  logic          req_fire;
  logic          rsp_taken;
  logic          rsp_drop;
  logic          fifo_has_room;
  logic          push;
  logic          pop;

  // Buffered entries plus outstanding requests bound how many more we may issue.
  assign credit_used     = SW'(count_q) + SW'(inflight_q);
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // Requests are suppressed during reset and in the redirect cycle itself.
  assign imem_req_valid = reset & ~redirect_valid & (credit_used < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp_taken     = imem_rsp_valid & (inflight_q != '0);
  assign rsp_drop      = rsp_taken & (discard_q != '0);
  assign fifo_has_room = (count_q != CW'(DEPTH)) | pop;
  assign push          = rsp_taken & (discard_q == '0) & ~redirect_valid & fifo_has_room;

  assign instr_valid = (count_q != '0);
  assign instr_data  = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]   : '0;
  assign pop         = instr_valid & instr_ready;

  // Next-state for fetch address, counters and FIFO pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    push_pc_d  = push_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_taken);
    discard_d  = discard_q - CW'(rsp_drop);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (push) begin
      wr_ptr_d  = wr_ptr_q + PW'(1);
      push_pc_d = push_pc_q + 32'd4;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    // Everything still outstanding after this edge belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      push_pc_d  = redirect_target;
      discard_d  = inflight_d;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      push_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      push_pc_q  <= push_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // FIFO storage; contents are only visible through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= push_pc_q;
      fifo_data_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule
